iord_mem_responder: RTL

- Memory-side responder for the processor's shared instruction/data address path.
- Accepts instruction-fetch requests (read-only) and data requests (read/write) and arbitrates between them.
- Serves each request from one internal single-port synchronous RAM of 16-bit words.
- Returns read data with a valid pulse; the datapath no longer drives RAM directly.

---
 rtl/iord_mem_responder_if.sv | 44 ++++
 rtl/iord_mem_responder.sv | 138 +++++++++++++
 2 files changed

// File: rtl/iord_mem_responder_if.sv
// Request/response bundle between the processor's shared I/D address path
// and the memory responder. The responder uses the slave modport and the
// requester (datapath or bench) uses the master modport.
// Latency/backpressure: see iord_mem_responder; req is held until its ack.
// Optional d_err (write-protect violation) exists only with IORD_WRITE_PROTECT_EN.
interface iord_mem_responder_if #(
  parameter int ADDR_W = 10
);
  // instruction-fetch channel (read-only)
  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic              i_ack;
  logic              i_valid;
  logic [15:0]       i_rdata;
  // data channel (read/write)
  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [15:0]       d_wdata;
  logic              d_ack;
  logic              d_valid;
  logic [15:0]       d_rdata;
  // responder status
  logic              busy;
`ifdef IORD_WRITE_PROTECT_EN
  logic              d_err;
`endif

  modport master (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata,
    input  i_ack, i_valid, i_rdata, d_ack, d_valid, d_rdata, busy
`ifdef IORD_WRITE_PROTECT_EN
    , input d_err
`endif
  );

  modport slave (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata,
    output i_ack, i_valid, i_rdata, d_ack, d_valid, d_rdata, busy
`ifdef IORD_WRITE_PROTECT_EN
    , output d_err
`endif
  );
endinterface

// File: rtl/iord_mem_responder.sv
// Memory responder: arbitrates fetch vs data requests onto one single-port
// 16-bit synchronous RAM (2^ADDR_W words).
// Latency: ack the cycle after the request is sampled, valid one cycle later;
// one access per 3 cycles. Backpressure: a losing or late requester simply
// holds req until its ack; requests are never dropped.
// Ports: clk_i, rst_i (async, active-high); bus = slave side of
// iord_mem_responder_if (i_* fetch channel, d_* data channel, busy, d_err).
// Optional feature macro IORD_WRITE_PROTECT_EN: suppresses data writes below
// TEXT_LIMIT and pulses d_err with d_valid; TEXT_LIMIT exists only then.
module iord_mem_responder #(
  parameter int ADDR_W = 10
`ifdef IORD_WRITE_PROTECT_EN
  , parameter int TEXT_LIMIT = 256
`endif
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  iord_mem_responder_if.slave    bus
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t            state_q, state_d;
  logic              prio_q, prio_d;       // 0: data wins a tie, 1: fetch wins
  logic              grant, grant_i;
  logic              sel_i_q;              // granted channel is fetch
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [15:0]       wdata_q;
  logic              i_ack_q, d_ack_q, i_valid_q, d_valid_q;
  logic [15:0]       i_hold_q, d_hold_q;   // last completed read per channel
  logic [15:0]       ram_rdata_q;
  logic              ram_we, ram_re, prot_hit;

  logic [15:0] mem [2**ADDR_W];

`ifdef IORD_WRITE_PROTECT_EN
  localparam logic [ADDR_W:0] TEXT_LIM_W = TEXT_LIMIT[ADDR_W:0];
  logic err_q;
  assign prot_hit = we_q && ({1'b0, addr_q} < TEXT_LIM_W);
`else
  assign prot_hit = 1'b0;
`endif

  // Next state and arbitration; grants are only issued from IDLE.
  always_comb begin
    state_d = state_q;
    prio_d  = prio_q;
    grant   = 1'b0;
    grant_i = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.i_req || bus.d_req) begin
          grant   = 1'b1;
          state_d = ACCESS;
          if (bus.i_req && bus.d_req) begin
            grant_i = prio_q;
            prio_d  = ~prio_q;   // loser of this tie wins the next one
          end else begin
            grant_i = bus.i_req;
          end
        end
      end
      ACCESS:  state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // RAM is touched only on the ACCESS->RESP edge. An async reset during
  // ACCESS drops state_q to IDLE before that edge, so the write never lands.
  assign ram_we = (state_q == ACCESS) && we_q && !prot_hit;
  assign ram_re = (state_q == ACCESS) && !we_q;

  always_ff @(posedge clk_i) begin
    if (ram_we) begin
      mem[addr_q] <= wdata_q;
    end else if (ram_re) begin
      ram_rdata_q <= mem[addr_q];
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      prio_q    <= 1'b0;
      sel_i_q   <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      i_ack_q   <= 1'b0;
      d_ack_q   <= 1'b0;
      i_valid_q <= 1'b0;
      d_valid_q <= 1'b0;
      i_hold_q  <= '0;
      d_hold_q  <= '0;
`ifdef IORD_WRITE_PROTECT_EN
      err_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      prio_q    <= prio_d;
      i_ack_q   <= grant && grant_i;
      d_ack_q   <= grant && !grant_i;
      i_valid_q <= (state_q == ACCESS) && sel_i_q;
      d_valid_q <= (state_q == ACCESS) && !sel_i_q;
`ifdef IORD_WRITE_PROTECT_EN
      err_q     <= (state_q == ACCESS) && !sel_i_q && prot_hit;
`endif
      if (grant) begin
        sel_i_q <= grant_i;
        we_q    <= !grant_i && bus.d_we;   // d_we only matters for a data grant
        addr_q  <= grant_i ? bus.i_addr : bus.d_addr;
        wdata_q <= bus.d_wdata;
      end
      // Capture the read word as RESP ends so rdata holds until the next read.
      if (state_q == RESP && sel_i_q) begin
        i_hold_q <= ram_rdata_q;
      end
      if (state_q == RESP && !sel_i_q && !we_q) begin
        d_hold_q <= ram_rdata_q;
      end
    end
  end

  // During RESP the fresh RAM word is shown directly; otherwise the held copy.
  assign bus.i_rdata = i_valid_q ? ram_rdata_q : i_hold_q;
  assign bus.d_rdata = (d_valid_q && !we_q) ? ram_rdata_q : d_hold_q;
  assign bus.i_ack   = i_ack_q;
  assign bus.d_ack   = d_ack_q;
  assign bus.i_valid = i_valid_q;
  assign bus.d_valid = d_valid_q;
  assign bus.busy    = (state_q != IDLE);
`ifdef IORD_WRITE_PROTECT_EN
  assign bus.d_err   = err_q;
`endif

endmodule
